// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Buffers word writes from the debug UART program stream in a small FIFO and
//   commits them, in order, to the instruction or data memory write port.
//   Tracks session word count, checksum and dropped-word overflow, holds
//   loader_busy while a session is open or words remain buffered, and pulses
//   load_done once the session is fully committed.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   uart_write_enable/addr/data    one-cycle word write from the debug unit
//   uart_complete                  one-cycle end-of-transfer pulse
//   imem_we/addr/wdata, imem_ready instruction memory write port + handshake
//   dmem_we/addr/wdata, dmem_ready data memory write port + handshake
//   loader_busy                    session open or FIFO non-empty (CPU stall)
//   load_done                      one-cycle pulse: session fully committed
//   word_count, checksum           accepted words / sum of accepted data
//   overflow_err                   sticky: a word was dropped this session
module uart_mem_loader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_write_enable,
    input  logic [ADDR_WIDTH-1:0] uart_addr,
    input  logic [DATA_WIDTH-1:0] uart_data,
    input  logic                  uart_complete,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-2:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    input  logic                  imem_ready,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-2:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    output logic                  loader_busy,
    output logic                  load_done,
    output logic [15:0]           word_count,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  overflow_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t        state;
    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    logic   empty, full, pop, push, head_dmem;
    entry_t head;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head      = mem[rd_ptr];
    assign head_dmem = head.addr[ADDR_WIDTH-1];

    // Port drive comes only from FIFO registers, so a push is visible the
    // cycle after its edge and never combinationally from the UART inputs.
    assign imem_we    = !empty && !head_dmem;
    assign dmem_we    = !empty &&  head_dmem;
    assign imem_addr  = imem_we ? head.addr[ADDR_WIDTH-2:0] : '0;
    assign imem_wdata = imem_we ? head.data : '0;
    assign dmem_addr  = dmem_we ? head.addr[ADDR_WIDTH-2:0] : '0;
    assign dmem_wdata = dmem_we ? head.data : '0;

    assign pop  = (imem_we && imem_ready) || (dmem_we && dmem_ready);
    // A full FIFO still takes a word when the head leaves in the same cycle.
    // Writes arriving during the DONE cycle are not part of any session.
    assign push = uart_write_enable && (state != DONE) && (!full || pop);

    assign loader_busy = (state == LOAD) || (state == DRAIN) || !empty;

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: uart_addr, data: uart_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            load_done    <= 1'b0;
            word_count   <= '0;
            checksum     <= '0;
            overflow_err <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    // First word opens the session and restarts the stats.
                    if (uart_write_enable) begin
                        state        <= LOAD;
                        word_count   <= 16'd1;
                        checksum     <= uart_data;
                        overflow_err <= 1'b0;
                    end
                end
                LOAD, DRAIN: begin
                    if (push) begin
                        word_count <= word_count + 16'd1;
                        checksum   <= checksum + uart_data;
                    end else if (uart_write_enable) begin
                        overflow_err <= 1'b1;
                    end
                    if (state == LOAD && uart_complete) begin
                        state <= DRAIN;
                    end else if (state == DRAIN && empty && !push) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_write_enable = 1'b0;
    logic [14:0] uart_addr = '0;
    logic [31:0] uart_data = '0;
    logic        uart_complete = 1'b0;
    logic        imem_we, dmem_we, loader_busy, load_done, overflow_err;
    logic [13:0] imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata, checksum;
    logic [15:0] word_count;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;

    uart_mem_loader #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .uart_write_enable(uart_write_enable), .uart_addr(uart_addr),
        .uart_data(uart_data), .uart_complete(uart_complete),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready),
        .loader_busy(loader_busy), .load_done(load_done),
        .word_count(word_count), .checksum(checksum), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {logic [14:0] a; logic [31:0] d;} w_t;
    w_t          q[$];
    bit          m_active, m_closing, m_done, chk_en;
    logic [15:0] m_wc;
    logic [31:0] m_cs;
    bit          m_ov;
    bit          m_pop, m_acc, m_done_now;
    int          m_size;

    // commits observed on the DUT ports, used for literal order checks
    typedef struct {bit tgt; logic [13:0] a; logic [31:0] d; int c;} c_t;
    c_t log_q[$];
    int cyc_n = 0, done_cnt = 0, done_cyc = 0;

    always @(posedge clk) begin
        cyc_n++;
        if (rst_n) begin
            if (imem_we && imem_ready) log_q.push_back('{1'b0, imem_addr, imem_wdata, cyc_n});
            if (dmem_we && dmem_ready) log_q.push_back('{1'b1, dmem_addr, dmem_wdata, cyc_n});
            if (load_done) begin done_cnt++; done_cyc = cyc_n; end
        end

        if (!rst_n) begin
            q.delete();
            m_active = 0; m_closing = 0; m_done = 0;
            m_wc = '0; m_cs = '0; m_ov = 0;
            chk_en = 1;
        end else begin
            m_size     = q.size();
            m_pop      = m_size > 0 && (q[0].a[14] ? dmem_ready : imem_ready);
            m_done_now = m_done;
            m_done     = 0;
            m_acc      = 0;
            if (uart_write_enable) begin
                if (!m_active && !m_done_now) begin
                    m_acc = 1; m_wc = 16'd1; m_cs = uart_data; m_ov = 0;
                end else if (m_active) begin
                    if (m_size < DEPTH || m_pop) begin
                        m_acc = 1; m_wc = m_wc + 16'd1; m_cs = m_cs + uart_data;
                    end else begin
                        m_ov = 1;
                    end
                end
            end
            // session ends once complete was seen and nothing is left or arriving
            if (m_active && m_closing && m_size == 0 && !m_acc) begin
                m_active = 0; m_closing = 0; m_done = 1;
            end else if (m_active && uart_complete) begin
                m_closing = 1;
            end
            if (!m_active && !m_done && m_acc) m_active = 1;
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back('{uart_addr, uart_data});
        end
    end

    logic e_i, e_d;
    always @(negedge clk) begin
        if (chk_en) begin
            e_i = q.size() > 0 && !q[0].a[14];
            e_d = q.size() > 0 &&  q[0].a[14];
            chk("imem_we", imem_we, e_i);
            chk("dmem_we", dmem_we, e_d);
            if (e_i) begin
                chk("imem_addr", imem_addr, q[0].a[13:0]);
                chk("imem_wdata", imem_wdata, q[0].d);
            end
            if (e_d) begin
                chk("dmem_addr", dmem_addr, q[0].a[13:0]);
                chk("dmem_wdata", dmem_wdata, q[0].d);
            end
            chk("loader_busy", loader_busy, m_active || q.size() > 0);
            chk("load_done", load_done, m_done);
            chk("word_count", word_count, m_wc);
            chk("checksum", checksum, m_cs);
            chk("overflow_err", overflow_err, m_ov);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [14:0] a, input logic [31:0] d);
        uart_write_enable = 1'b1; uart_addr = a; uart_data = d;
        cyc();
        uart_write_enable = 1'b0;
    endtask

    task automatic complete();
        uart_complete = 1'b1;
        cyc();
        uart_complete = 1'b0;
    endtask

    int lb;

    initial begin
        // reset values
        repeat (3) cyc();
        chk("rst imem_we", imem_we, 0);
        chk("rst dmem_we", dmem_we, 0);
        chk("rst imem_addr", imem_addr, 0);
        chk("rst dmem_wdata", dmem_wdata, 0);
        chk("rst busy", loader_busy, 0);
        chk("rst load_done", load_done, 0);
        chk("rst word_count", word_count, 0);
        chk("rst checksum", checksum, 0);
        chk("rst overflow", overflow_err, 0);
        rst_n = 1'b1;
        cyc();

        // basic imem load
        imem_ready = 1'b1;
        lb = log_q.size();
        put(15'h0000, 32'h11111111);
        put(15'h0001, 32'h22222222);
        put(15'h0002, 32'h33333333);
        complete();
        repeat (8) cyc();
        chk("t1 word_count", word_count, 3);
        chk("t1 checksum", checksum, 32'h66666666);
        chk("t1 done_cnt", done_cnt, 1);
        chk("t1 busy", loader_busy, 0);
        chk("t1 commits", log_q.size() - lb, 3);
        for (int i = 0; i < 3 && lb + i < log_q.size(); i++) begin
            chk("t1 commit addr", log_q[lb+i].a, i);
            chk("t1 commit data", log_q[lb+i].d, 32'h11111111 * (i + 1));
        end

        // routing to dmem
        imem_ready = 1'b0; dmem_ready = 1'b1;
        lb = log_q.size();
        put(15'h4005, 32'hDEADBEEF);
        chk("t2 dmem_we", dmem_we, 1);
        chk("t2 dmem_addr", dmem_addr, 14'h0005);
        chk("t2 dmem_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("t2 imem_we", imem_we, 0);
        complete();
        repeat (8) cyc();
        chk("t2 commits", log_q.size() - lb, 1);
        if (log_q.size() > lb) chk("t2 target", log_q[lb].tgt, 1);
        chk("t2 done_cnt", done_cnt, 2);

        // backpressure and overflow
        imem_ready = 1'b0; dmem_ready = 1'b0;
        lb = log_q.size();
        for (int i = 0; i < 6; i++) put(15'h0010 + 15'(i), 32'hA0 + 32'(i));
        complete();
        chk("t3 overflow", overflow_err, 1);
        chk("t3 word_count", word_count, 4);
        chk("t3 checksum", checksum, 32'h286);
        chk("t3 head addr", imem_addr, 14'h0010);
        repeat (3) cyc();
        chk("t3 stall addr", imem_addr, 14'h0010);
        chk("t3 stall data", imem_wdata, 32'hA0);
        chk("t3 busy stalled", loader_busy, 1);
        imem_ready = 1'b1;
        repeat (10) cyc();
        chk("t3 commits", log_q.size() - lb, 4);
        for (int i = 0; i < 4 && lb + i < log_q.size(); i++) begin
            chk("t3 order addr", log_q[lb+i].a, 14'h0010 + 14'(i));
            chk("t3 order data", log_q[lb+i].d, 32'hA0 + 32'(i));
        end
        for (int i = 1; i < 4 && lb + i < log_q.size(); i++)
            chk("t3 no bubble", log_q[lb+i].c - log_q[lb+i-1].c, 1);
        chk("t3 done_cnt", done_cnt, 3);

        // full FIFO push+pop together, then write with complete
        imem_ready = 1'b0;
        lb = log_q.size();
        for (int i = 0; i < 4; i++) put(15'h0020 + 15'(i), 32'hB0 + 32'(i));
        imem_ready = 1'b1;
        put(15'h0024, 32'hB4);
        uart_complete = 1'b1;
        put(15'h0025, 32'hB5);
        uart_complete = 1'b0;
        chk("t4 overflow", overflow_err, 0);
        chk("t4 word_count", word_count, 6);
        chk("t4 checksum", checksum, 32'h42F);
        repeat (10) cyc();
        chk("t4 commits", log_q.size() - lb, 6);
        for (int i = 0; i < 6 && lb + i < log_q.size(); i++)
            chk("t4 order addr", log_q[lb+i].a, 14'h0020 + 14'(i));
        chk("t4 done_cnt", done_cnt, 4);
        if (log_q.size() > 0) chk("t4 done after commit", done_cyc > log_q[log_q.size()-1].c, 1);

        // reset mid-drain
        imem_ready = 1'b0;
        lb = log_q.size();
        put(15'h0030, 32'h1);
        put(15'h0031, 32'h2);
        complete();
        cyc();
        chk("t5 busy before rst", loader_busy, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t5 busy", loader_busy, 0);
        chk("t5 imem_we", imem_we, 0);
        chk("t5 word_count", word_count, 0);
        imem_ready = 1'b1;
        repeat (5) cyc();
        chk("t5 no done", done_cnt, 4);
        chk("t5 no commits", log_q.size() - lb, 0);
        put(15'h0032, 32'h7);
        chk("t5 new word_count", word_count, 1);
        chk("t5 new checksum", checksum, 7);
        complete();
        repeat (8) cyc();
        chk("t5 done_cnt", done_cnt, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
